// File: rtl/mem_arbiter_pkg.sv
// rtl/mem_arbiter_pkg.sv - state encodings and constants shared by the memory arbiter
package mem_arbiter_pkg;

  typedef enum logic [1:0] {
    MEM_ARB_IDLE = 2'd0,
    MEM_ARB_INST = 2'd1,
    MEM_ARB_DATA = 2'd2,
    MEM_ARB_DONE = 2'd3
  } arb_state_e;

  // Word returned to the core when a transaction is aborted by the watchdog
  localparam logic [31:0] MEM_ARB_ERR_WORD = 32'hDEAD_BEEF;

endpackage

// File: rtl/mem_arbiter_if.sv
// rtl/mem_arbiter_if.sv - core fetch/data ports and memory port bundled for the arbiter
interface mem_arbiter_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic                  inst_ren;
  logic [ADDR_WIDTH-1:0] inst_addr;
  logic [DATA_WIDTH-1:0] inst_data;
  logic                  inst_stall;
  logic                  mem_ren;
  logic                  mem_wen;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [DATA_WIDTH-1:0] mem_dout;
  logic [DATA_WIDTH-1:0] mem_din;
  logic                  mem_stall;
  logic                  ram_req;
  logic                  ram_we;
  logic [ADDR_WIDTH-1:0] ram_addr;
  logic [DATA_WIDTH-1:0] ram_wdata;
  logic [DATA_WIDTH-1:0] ram_rdata;
  logic                  ram_ack;
  logic                  bus_err;

  modport slave (
    input  inst_ren, inst_addr, mem_ren, mem_wen, mem_addr, mem_dout, ram_rdata, ram_ack,
    output inst_data, inst_stall, mem_din, mem_stall, ram_req, ram_we, ram_addr, ram_wdata,
    output bus_err
  );

  modport master (
    output inst_ren, inst_addr, mem_ren, mem_wen, mem_addr, mem_dout, ram_rdata, ram_ack,
    input  inst_data, inst_stall, mem_din, mem_stall, ram_req, ram_we, ram_addr, ram_wdata,
    input  bus_err
  );
endinterface

// File: rtl/mem_arb_timeout.sv
// rtl/mem_arb_timeout.sv - ack watchdog: cycle counter with expiry compare at TIMEOUT
module mem_arb_timeout #(
  parameter int TIMEOUT = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic run,
  output logic expired
);
  localparam int CW = ($clog2(TIMEOUT + 1) > 8) ? $clog2(TIMEOUT + 1) : 8;

  logic [CW-1:0] cnt_q, cnt_d;

  // Count is 0 in the first outstanding cycle, so expiry after TIMEOUT cycles sits at TIMEOUT-1
  assign expired = run && (cnt_q == CW'(TIMEOUT - 1));

  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (run && !expired) begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end
endmodule

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - fetch/data arbiter for a single-ported variable-latency memory
// Optional ack watchdog and sticky bus_err enabled by MEM_ARB_TIMEOUT_EN.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int TIMEOUT    = 255
) (
  input logic          clk,
  input logic          rst,
  mem_arbiter_if.slave bus
);
  localparam logic [DATA_WIDTH-1:0] ERR_WORD = DATA_WIDTH'(MEM_ARB_ERR_WORD);

  arb_state_e            state_q, state_d;
  logic                  gnt_data_q, gnt_data_d;
  logic                  last_data_q, last_data_d;
  logic                  ram_req_q, ram_req_d;
  logic                  ram_we_q, ram_we_d;
  logic [ADDR_WIDTH-1:0] ram_addr_q, ram_addr_d;
  logic [DATA_WIDTH-1:0] ram_wdata_q, ram_wdata_d;
  logic [DATA_WIDTH-1:0] inst_data_q, inst_data_d;
  logic [DATA_WIDTH-1:0] mem_din_q, mem_din_d;
  logic                  bus_err_q, bus_err_d;

  logic data_req, pick_data, grant, busy, tmo_expired;

  assign data_req = bus.mem_ren | bus.mem_wen;
  assign busy     = (state_q == MEM_ARB_INST) || (state_q == MEM_ARB_DATA);

`ifdef MEM_ARB_TIMEOUT_EN
  mem_arb_timeout #(.TIMEOUT(TIMEOUT)) u_timeout (
    .clk     (clk),
    .rst     (rst),
    .clear   (grant),
    .run     (busy),
    .expired (tmo_expired)
  );
`else
  logic unused_timeout;
  assign tmo_expired    = 1'b0;
  assign unused_timeout = ^{grant, busy, (TIMEOUT != 0)};
`endif

  always_comb begin
    state_d     = state_q;
    gnt_data_d  = gnt_data_q;
    last_data_d = last_data_q;
    ram_req_d   = ram_req_q;
    ram_we_d    = ram_we_q;
    ram_addr_d  = ram_addr_q;
    ram_wdata_d = ram_wdata_q;
    inst_data_d = inst_data_q;
    mem_din_d   = mem_din_q;
    bus_err_d   = bus_err_q;
    pick_data   = 1'b0;
    grant       = 1'b0;
    case (state_q)
      MEM_ARB_IDLE: begin
        if (bus.inst_ren || data_req) begin
          // Data wins a tie unless it also won the previous grant
          pick_data   = data_req && (!bus.inst_ren || !last_data_q);
          grant       = 1'b1;
          state_d     = pick_data ? MEM_ARB_DATA : MEM_ARB_INST;
          gnt_data_d  = pick_data;
          last_data_d = pick_data;
          ram_req_d   = 1'b1;
          ram_we_d    = pick_data & bus.mem_wen;
          ram_addr_d  = pick_data ? bus.mem_addr : bus.inst_addr;
          ram_wdata_d = pick_data ? bus.mem_dout : '0;
        end
      end
      MEM_ARB_INST, MEM_ARB_DATA: begin
        if (bus.ram_ack) begin
          ram_req_d = 1'b0;
          state_d   = MEM_ARB_DONE;
          if (!gnt_data_q) begin
            inst_data_d = bus.ram_rdata;
          end else if (!ram_we_q) begin
            mem_din_d = bus.ram_rdata;
          end
        end else if (tmo_expired) begin
          ram_req_d = 1'b0;
          state_d   = MEM_ARB_DONE;
          bus_err_d = 1'b1;
          if (!gnt_data_q) begin
            inst_data_d = ERR_WORD;
          end else if (!ram_we_q) begin
            mem_din_d = ERR_WORD;
          end
        end
      end
      default: begin
        state_d = MEM_ARB_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= MEM_ARB_IDLE;
      gnt_data_q  <= 1'b0;
      last_data_q <= 1'b0;
      ram_req_q   <= 1'b0;
      ram_we_q    <= 1'b0;
      ram_addr_q  <= '0;
      ram_wdata_q <= '0;
      inst_data_q <= '0;
      mem_din_q   <= '0;
      bus_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      gnt_data_q  <= gnt_data_d;
      last_data_q <= last_data_d;
      ram_req_q   <= ram_req_d;
      ram_we_q    <= ram_we_d;
      ram_addr_q  <= ram_addr_d;
      ram_wdata_q <= ram_wdata_d;
      inst_data_q <= inst_data_d;
      mem_din_q   <= mem_din_d;
      bus_err_q   <= bus_err_d;
    end
  end

  // Stalls are forced low while reset is asserted so the core sees no hold
  assign bus.inst_stall = rst & bus.inst_ren &
                          ~((state_q == MEM_ARB_DONE) & ~gnt_data_q);
  assign bus.mem_stall  = rst & data_req &
                          ~((state_q == MEM_ARB_DONE) & gnt_data_q);

  assign bus.ram_req   = ram_req_q;
  assign bus.ram_we    = ram_we_q;
  assign bus.ram_addr  = ram_addr_q;
  assign bus.ram_wdata = ram_wdata_q;
  assign bus.inst_data = inst_data_q;
  assign bus.mem_din   = mem_din_q;
  assign bus.bus_err   = bus_err_q;
endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - directed self-checking bench for mem_arbiter
module tb_mem_arbiter;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int   vectors = 0;
  int   miscompares = 0;

  logic        mem_enable = 1'b1;
  int          mcnt = 0;
  bit          acked = 1'b0;
  logic [31:0] glog[$];

  always #5 clk = ~clk;

  mem_arbiter_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus ();

  mem_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .TIMEOUT(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    case (a)
      32'h0000_0040: return 32'h2001_0005;
      32'h0000_0100: return 32'h1111_0100;
      default:       return a ^ 32'h5A5A_0000;
    endcase
  endfunction

  function automatic int mem_wait(input logic [31:0] a);
    return (a == 32'h0000_0100) ? 3 : 0;
  endfunction

  // Memory model acts on the falling edge so ack is stable around the rising edge
  always @(negedge clk) begin
    if (!bus.ram_req) begin
      mcnt        = 0;
      acked       = 1'b0;
      bus.ram_ack = 1'b0;
    end else if (acked) begin
      bus.ram_ack = 1'b0;
    end else if (mem_enable && mcnt == mem_wait(bus.ram_addr)) begin
      bus.ram_ack   = 1'b1;
      bus.ram_rdata = mem_word(bus.ram_addr);
      acked         = 1'b1;
      glog.push_back(bus.ram_addr);
    end else begin
      mcnt++;
    end
  end

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  initial begin
    int n;
    int loads;
    logic [31:0] g;

    bus.inst_ren  = 1'b0;
    bus.inst_addr = '0;
    bus.mem_ren   = 1'b0;
    bus.mem_wen   = 1'b0;
    bus.mem_addr  = '0;
    bus.mem_dout  = '0;
    bus.ram_rdata = '0;
    bus.ram_ack   = 1'b0;

    // Reset state
    tick(); tick();
    check_val("rst_ram_req", bus.ram_req, 0);
    check_val("rst_ram_addr", bus.ram_addr, 0);
    check_val("rst_inst_data", bus.inst_data, 0);
    check_val("rst_mem_din", bus.mem_din, 0);
    check_val("rst_bus_err", bus.bus_err, 0);
    check_val("rst_stalls", {bus.inst_stall, bus.mem_stall}, 0);
    rst = 1'b1;
    tick();

    // Fetch only, zero-wait
    bus.inst_ren  = 1'b1;
    bus.inst_addr = 32'h0000_0040;
    #1 check_val("f_c0_stall", bus.inst_stall, 1);
    tick();
    check_val("f_c1_req", bus.ram_req, 1);
    check_val("f_c1_addr", bus.ram_addr, 32'h40);
    check_val("f_c1_we", bus.ram_we, 0);
    check_val("f_c1_stall", bus.inst_stall, 1);
    tick();
    check_val("f_c2_stall", bus.inst_stall, 0);
    check_val("f_c2_data", bus.inst_data, 32'h2001_0005);
    check_val("f_c2_req", bus.ram_req, 0);
    check_val("f_c2_mstall", bus.mem_stall, 0);
    bus.inst_ren = 1'b0;
    tick();
    check_val("f_c3_req", bus.ram_req, 0);
    check_val("f_c3_hold", bus.inst_data, 32'h2001_0005);

    // Simultaneous fetch and load: load (3 waits) first, then fetch (zero-wait)
    bus.inst_ren  = 1'b1;
    bus.inst_addr = 32'h0000_0044;
    bus.mem_ren   = 1'b1;
    bus.mem_addr  = 32'h0000_0100;
    for (int c = 1; c <= 8; c++) begin
      tick();
      if (c < 8) check_val($sformatf("s_c%0d_istall", c), bus.inst_stall, 1);
      if (c == 1) check_val("s_c1_addr", bus.ram_addr, 32'h100);
      if (c == 4) check_val("s_c4_mstall", bus.mem_stall, 1);
      if (c == 5) begin
        check_val("s_c5_mstall", bus.mem_stall, 0);
        check_val("s_c5_din", bus.mem_din, 32'h1111_0100);
        bus.mem_ren = 1'b0;
      end
      if (c == 7) check_val("s_c7_addr", bus.ram_addr, 32'h44);
      if (c == 8) begin
        check_val("s_c8_istall", bus.inst_stall, 0);
        check_val("s_c8_data", bus.inst_data, 32'h5A5A_0044);
      end
    end
    bus.inst_ren = 1'b0;
    tick();

    // Fairness: two loads with a fetch pending throughout
    glog.delete();
    bus.mem_ren   = 1'b1;
    bus.mem_addr  = 32'h0000_0300;
    bus.inst_ren  = 1'b1;
    bus.inst_addr = 32'h0000_0048;
    loads = 0;
    n = 0;
    while (loads < 2 && n < 40) begin
      tick();
      n++;
      if (bus.mem_ren && !bus.mem_stall) begin
        loads++;
        if (loads == 1) bus.mem_addr = 32'h0000_0304;
        else bus.mem_ren = 1'b0;
      end
      if (bus.inst_ren && !bus.inst_stall) bus.inst_ren = 1'b0;
    end
    check_val("fair_in_time", (n < 40), 1);
    check_val("fair_count", glog.size(), 3);
    g = (glog.size() > 0) ? glog[0] : 32'hFFFF_FFFF;
    check_val("fair_1st", g, 32'h300);
    g = (glog.size() > 1) ? glog[1] : 32'hFFFF_FFFF;
    check_val("fair_2nd", g, 32'h48);
    g = (glog.size() > 2) ? glog[2] : 32'hFFFF_FFFF;
    check_val("fair_3rd", g, 32'h304);
    bus.inst_ren = 1'b0;
    tick();

    // Store with ren and wen both high is a write; mem_din unchanged
    bus.mem_ren  = 1'b1;
    bus.mem_wen  = 1'b1;
    bus.mem_addr = 32'h0000_0200;
    bus.mem_dout = 32'hCAFE_0001;
    tick();
    check_val("st_we", bus.ram_we, 1);
    check_val("st_addr", bus.ram_addr, 32'h200);
    check_val("st_wdata", bus.ram_wdata, 32'hCAFE_0001);
    tick();
    check_val("st_mstall", bus.mem_stall, 0);
    check_val("st_din_hold", bus.mem_din, 32'h5A5A_0304);
    bus.mem_ren = 1'b0;
    bus.mem_wen = 1'b0;
    tick();

    // Reset mid-transaction, then held request restarts
    bus.mem_ren  = 1'b1;
    bus.mem_addr = 32'h0000_0100;
    tick();
    check_val("rm_c1_req", bus.ram_req, 1);
    tick();
    rst = 1'b0;
    #1;
    check_val("rm_req_drop", bus.ram_req, 0);
    check_val("rm_mstall", bus.mem_stall, 0);
    check_val("rm_din_lost", bus.mem_din, 0);
    tick();
    rst = 1'b1;
    tick();
    check_val("rm_restart_req", bus.ram_req, 1);
    check_val("rm_restart_addr", bus.ram_addr, 32'h100);
    n = 0;
    while (bus.mem_stall && n < 20) begin
      tick();
      n++;
    end
    check_val("rm_done_in_time", (n < 20), 1);
    check_val("rm_din", bus.mem_din, 32'h1111_0100);
    bus.mem_ren = 1'b0;
    tick();

`ifdef MEM_ARB_TIMEOUT_EN
    // Load with no ack: aborted after 4 cycles with error word
    mem_enable   = 1'b0;
    bus.mem_ren  = 1'b1;
    bus.mem_addr = 32'h0000_0500;
    for (int c = 1; c <= 5; c++) begin
      tick();
      if (c < 5) check_val($sformatf("to_c%0d_req", c), bus.ram_req, 1);
    end
    check_val("to_req_drop", bus.ram_req, 0);
    check_val("to_mstall", bus.mem_stall, 0);
    check_val("to_din", bus.mem_din, 32'hDEAD_BEEF);
    check_val("to_bus_err", bus.bus_err, 1);
    bus.mem_ren = 1'b0;
    mem_enable  = 1'b1;
    tick(); tick(); tick();
    check_val("to_err_sticky", bus.bus_err, 1);
`else
    check_val("no_bus_err", bus.bus_err, 0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
